audio_tone_source: RTL and testbench

AUDIO_TONE_SOURCE -- requirements
Module: audio_tone_source

---
 rtl/audio_tone_source.sv | 195 +++++++++++++++++++
 tb/tb_audio_tone_source.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_source.sv
// ---------------------------------------------------------------------------
// audio_tone_source
//
// Square-wave tone generator feeding two independent valid/ready sinks
// (left and right channel). A tone is requested with a one-cycle start
// pulse; the note parameters are captured at that moment. The tone then
// emits note_len stereo samples. Each sample is offered on both channels
// with identical data, and the next sample is produced only after both
// channels have taken the current one.
//
// Parameters
//   AMPLITUDE     full-scale square-wave magnitude (1..32767)
//
// Ports
//   clk_clk       single clock, rising edge
//   reset_reset_n synchronous active-low reset
//   start         one-cycle tone request, honoured only when idle
//   stop          abort the current tone, honoured in any state
//   note_step     phase increment per sample        (latched on start)
//   note_len      number of stereo samples          (latched on start)
//   volume        attenuation right-shift amount    (latched on start)
//   mute          force zero samples                (latched on start)
//   left_data     left sample, two's complement
//   left_valid    left sample valid
//   left_ready    left sink ready
//   right_data    right sample, always equal to left_data
//   right_valid   right sample valid
//   right_ready   right sink ready
//   busy          high whenever a tone is in progress
//   done          one-cycle pulse on normal tone completion
// ---------------------------------------------------------------------------
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no tone; waiting for start
// PRESENT | sample register offered on both channels until both taken
// ADVANCE | one cycle: step phase, bump count, decide next sample or end
//
module audio_tone_source #(
  parameter logic [15:0] AMPLITUDE = 16'h3FFF
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] note_step,
  input  logic [15:0] note_len,
  input  logic [2:0]  volume,
  input  logic        mute,
  output logic [15:0] left_data,
  output logic        left_valid,
  input  logic        left_ready,
  output logic [15:0] right_data,
  output logic        right_valid,
  input  logic        right_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  state_t      state;

  logic [15:0] step_q;
  logic [15:0] len_q;
  logic [2:0]  vol_q;
  logic        mute_q;

  logic [15:0] phase;
  logic [15:0] count;
  logic        left_taken;
  logic        right_taken;
  logic [15:0] sample_q;
  logic        done_q;

  // Sample rule: mute wins, otherwise the MSB of the phase selects the
  // positive or negative half of the square wave.
  function automatic logic [15:0] calc_sample(
    input logic [15:0] ph,
    input logic [2:0]  vol,
    input logic        mt
  );
    logic [15:0] amp;
    amp = AMPLITUDE >> vol;
    if (mt) begin
      calc_sample = 16'h0000;
    end else if (ph[15]) begin
      calc_sample = (~amp) + 16'd1;
    end else begin
      calc_sample = amp;
    end
  endfunction

  logic        left_xfer;
  logic        right_xfer;
  logic        left_taken_nxt;
  logic        right_taken_nxt;
  logic [15:0] phase_nxt;
  logic [15:0] count_nxt;

  assign left_xfer       = left_valid && left_ready;
  assign right_xfer      = right_valid && right_ready;
  assign left_taken_nxt  = left_taken || left_xfer;
  assign right_taken_nxt = right_taken || right_xfer;
  assign phase_nxt       = phase + step_q;
  assign count_nxt       = count + 16'd1;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state       <= IDLE;
      step_q      <= 16'h0000;
      len_q       <= 16'h0000;
      vol_q       <= 3'd0;
      mute_q      <= 1'b0;
      phase       <= 16'h0000;
      count       <= 16'h0000;
      left_taken  <= 1'b0;
      right_taken <= 1'b0;
      sample_q    <= 16'h0000;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // stop has priority over a same-cycle start
          if (start && !stop) begin
            if (note_len != 16'h0000) begin
              step_q      <= note_step;
              len_q       <= note_len;
              vol_q       <= volume;
              mute_q      <= mute;
              phase       <= 16'h0000;
              count       <= 16'h0000;
              left_taken  <= 1'b0;
              right_taken <= 1'b0;
              // first sample uses the incoming controls, phase is zero
              sample_q    <= calc_sample(16'h0000, volume, mute);
              state       <= PRESENT;
            end else begin
              done_q <= 1'b1;
            end
          end
        end

        PRESENT: begin
          if (stop) begin
            left_taken  <= 1'b0;
            right_taken <= 1'b0;
            state       <= IDLE;
          end else begin
            left_taken  <= left_taken_nxt;
            right_taken <= right_taken_nxt;
            if (left_taken_nxt && right_taken_nxt) begin
              state <= ADVANCE;
            end
          end
        end

        ADVANCE: begin
          phase       <= phase_nxt;
          count       <= count_nxt;
          left_taken  <= 1'b0;
          right_taken <= 1'b0;
          if (stop) begin
            state <= IDLE;
          end else if (count_nxt == len_q) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            sample_q <= calc_sample(phase_nxt, vol_q, mute_q);
            state    <= PRESENT;
          end
        end

        default: begin
          left_taken  <= 1'b0;
          right_taken <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign left_valid  = (state == PRESENT) && !left_taken;
  assign right_valid = (state == PRESENT) && !right_taken;
  assign left_data   = sample_q;
  assign right_data  = sample_q;
  assign busy        = (state != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_audio_tone_source.sv
module tb_audio_tone_source;

  localparam logic [15:0] AMP = 16'h3FFF;

  logic        clk_clk;
  logic        reset_reset_n;
  logic        start;
  logic        stop;
  logic [15:0] note_step;
  logic [15:0] note_len;
  logic [2:0]  volume;
  logic        mute;
  logic [15:0] left_data;
  logic        left_valid;
  logic        left_ready;
  logic [15:0] right_data;
  logic        right_valid;
  logic        right_ready;
  logic        busy;
  logic        done;

  audio_tone_source #(.AMPLITUDE(AMP)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .start         (start),
    .stop          (stop),
    .note_step     (note_step),
    .note_len      (note_len),
    .volume        (volume),
    .mute          (mute),
    .left_data     (left_data),
    .left_valid    (left_valid),
    .left_ready    (left_ready),
    .right_data    (right_data),
    .right_valid   (right_valid),
    .right_ready   (right_ready),
    .busy          (busy),
    .done          (done)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_l[$];
  logic [15:0] exp_r[$];
  int          done_exp = 0;
  int          l_xfers = 0;
  int          r_xfers = 0;
  bit          rdy_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sample k of a tone has phase k*step mod 2^16.
  function automatic logic [15:0] model_sample(input int ph, input int vol, input bit mt);
    int a;
    a = int'(AMP) >> vol;
    if (mt) return 16'h0000;
    if (ph >= 32768) return 16'(65536 - a);
    return 16'(a);
  endfunction

  task automatic push_tone(input logic [15:0] step, input logic [15:0] len,
                           input logic [2:0] vol, input bit mt);
    int s;
    logic [15:0] v;
    s = int'(step);
    for (int k = 0; k < int'(len); k++) begin
      v = model_sample((k * s) & 32'hFFFF, int'(vol), mt);
      exp_l.push_back(v);
      exp_r.push_back(v);
    end
    done_exp++;
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
    if (rdy_mode) begin
      left_ready  = 1'($urandom_range(0, 1));
      right_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start_tone(input logic [15:0] step, input logic [15:0] len,
                            input logic [2:0] vol, input bit mt);
    note_step = step;
    note_len  = len;
    volume    = vol;
    mute      = mt;
    start     = 1'b1;
    push_tone(step, len, vol, mt);
    tick();
    start     = 1'b0;
    note_step = 16'($urandom);
    note_len  = 16'($urandom);
    volume    = 3'($urandom);
    mute      = 1'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    tick();
    check("left_queue_drained", exp_l.size(), 0);
    check("right_queue_drained", exp_r.size(), 0);
    check("done_count", done_exp, 0);
  endtask

  task automatic flush_model();
    exp_l.delete();
    exp_r.delete();
    done_exp = 0;
  endtask

  // Monitor: transfers happen at the next rising edge when valid&&ready
  // is seen here on the falling edge.
  logic        l_hold, r_hold;
  logic [15:0] l_hold_data, r_hold_data;
  initial begin
    l_hold = 1'b0;
    r_hold = 1'b0;
    l_hold_data = '0;
    r_hold_data = '0;
  end

  always @(negedge clk_clk) begin
    if (reset_reset_n) begin
      if (l_hold && left_valid) check("left_hold_stable", left_data, l_hold_data);
      if (r_hold && right_valid) check("right_hold_stable", right_data, r_hold_data);
      if (left_valid && right_valid) check("left_eq_right", left_data, right_data);
      if (left_valid && left_ready) begin
        l_xfers++;
        if (exp_l.size() == 0) check("left_unexpected_xfer", 32'(left_data), 32'h1_0000);
        else check("left_sample", left_data, exp_l.pop_front());
      end
      if (right_valid && right_ready) begin
        r_xfers++;
        if (exp_r.size() == 0) check("right_unexpected_xfer", 32'(right_data), 32'h1_0000);
        else check("right_sample", right_data, exp_r.pop_front());
      end
      if (done) begin
        if (done_exp == 0) check("unexpected_done", 32'd1, 32'd0);
        else done_exp--;
      end
      l_hold      <= left_valid && !left_ready;
      r_hold      <= right_valid && !right_ready;
      l_hold_data <= left_data;
      r_hold_data <= right_data;
    end else begin
      l_hold <= 1'b0;
      r_hold <= 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int l0, r0;
    reset_reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    note_step = '0;
    note_len = '0;
    volume = '0;
    mute = 1'b0;
    left_ready = 1'b0;
    right_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_left_valid", 32'(left_valid), 0);
    check("rst_right_valid", 32'(right_valid), 0);
    check("rst_left_data", left_data, 0);
    check("rst_right_data", right_data, 0);
    reset_reset_n = 1'b1;
    tick();

    // basic tone, both sinks always ready: done 8 cycles after first PRESENT
    left_ready = 1'b1;
    right_ready = 1'b1;
    l0 = l_xfers;
    r0 = r_xfers;
    start_tone(16'h4000, 16'd4, 3'd0, 1'b0);
    check("busy_after_start", 32'(busy), 1);
    for (i = 0; i < 20; i++) begin
      if (done) break;
      tick();
    end
    check("done_latency", i, 8);
    check("busy_after_done", 32'(busy), 0);
    wait_idle(10);
    check("basic_left_xfers", l_xfers - l0, 4);
    check("basic_right_xfers", r_xfers - r0, 4);

    // attenuated and muted tones
    start_tone(16'h4000, 16'd4, 3'd1, 1'b0);
    wait_idle(40);
    l0 = l_xfers;
    r0 = r_xfers;
    start_tone(16'h4000, 16'd4, 3'd0, 1'b1);
    wait_idle(40);
    check("mute_left_xfers", l_xfers - l0, 4);
    check("mute_right_xfers", r_xfers - r0, 4);

    // right sink stalls while left is ready
    left_ready = 1'b1;
    right_ready = 1'b0;
    l0 = l_xfers;
    start_tone(16'h4000, 16'd2, 3'd0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_left_valid", 32'(left_valid), 0);
      check("stall_right_valid", 32'(right_valid), 1);
      check("stall_right_data", right_data, 16'h3FFF);
      tick();
    end
    check("stall_left_xfers", l_xfers - l0, 1);
    right_ready = 1'b1;
    check("stall_right_still_valid", 32'(right_valid), 1);
    tick();
    check("advance_valids", {30'd0, left_valid, right_valid}, 0);
    check("advance_busy", 32'(busy), 1);
    wait_idle(20);

    // zero-length tone
    start_tone(16'h1234, 16'd0, 3'd0, 1'b0);
    check("len0_done", 32'(done), 1);
    check("len0_valid", {30'd0, left_valid, right_valid}, 0);
    check("len0_busy", 32'(busy), 0);
    wait_idle(5);

    // start while busy is ignored
    l0 = l_xfers;
    r0 = r_xfers;
    start_tone(16'h2000, 16'd3, 3'd2, 1'b0);
    note_len = 16'd7;
    note_step = 16'h8000;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(30);
    check("busy_start_left_xfers", l_xfers - l0, 3);
    check("busy_start_right_xfers", r_xfers - r0, 3);

    // phase wrap-around
    start_tone(16'hFFFF, 16'd3, 3'd0, 1'b0);
    wait_idle(20);

    // stop in the second PRESENT cycle
    start_tone(16'h1000, 16'd10, 3'd0, 1'b0);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_valids", {30'd0, left_valid, right_valid}, 0);
    check("stop_busy", 32'(busy), 0);
    flush_model();
    tick();
    check("stop_no_done", 32'(done), 0);

    // stop and start together in IDLE
    note_len = 16'd5;
    note_step = 16'h0100;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("stop_start_busy", 32'(busy), 0);
    tick();
    check("stop_start_no_done", 32'(done), 0);

    // reset mid-tone
    start_tone(16'h3000, 16'd10, 3'd0, 1'b0);
    repeat (3) tick();
    reset_reset_n = 1'b0;
    tick();
    check("midrst_outputs",
          {left_data, 12'd0, left_valid, right_valid, busy, done}, 32'd0);
    check("midrst_right_data", right_data, 0);
    flush_model();
    reset_reset_n = 1'b1;
    tick();
    check("midrst_no_done", 32'(done), 0);

    // randomized tones with random sink backpressure
    rdy_mode = 1'b1;
    for (int t = 0; t < 25; t++) begin
      logic [15:0] st, ln;
      st = 16'($urandom);
      ln = 16'($urandom_range(0, 12));
      start_tone(st, ln, 3'($urandom), 1'($urandom_range(0, 3) == 0));
      wait_idle(40 * int'(ln) + 20);
    end
    rdy_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
